bus_host_rr_arbiter: RTL and testbench
======================================

// Module: bus_host_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream bus port between NrHosts
//  requesters, e.g. core data port, debug SBA host and a future DMA. It sits
//  between the hosts and the address-decoding bus/device fabric.
//  It tracks outstanding transactions in order and routes each response back
//  to the host that issued it.
//  A per-transaction watchdog returns a bus error to the owner when a device
//  does not respond in time, so a hung peripheral cannot lock up the core.
// PARAMETERS
//  NrHosts        3    number of requesting hosts (>=2)
//  MaxOutstanding 4    depth of the in-order response-owner FIFO (power of 2)
//  TimeoutCycles  256  cycles the oldest transaction may wait for rvalid
//  DataWidth      32   data bus width
//  AddressWidth   32   address bus width
// PORTS
//  clk_i         in   1                     system clock
//  rst_ni        in   1                     asynchronous active-low reset
//  host_req_i    in   1 [NrHosts]           host request
//  host_gnt_o    out  1 [NrHosts]           host grant (comb., same cycle)
//  host_addr_i   in   AddressWidth [NrHosts]  host address
//  host_we_i     in   1 [NrHosts]           host write enable
//  host_be_i     in   DataWidth/8 [NrHosts] host byte enables
//  host_wdata_i  in   DataWidth [NrHosts]   host write data
//  host_rvalid_o out  1 [NrHosts]           response valid to owner
//  host_rdata_o  out  DataWidth [NrHosts]   response data
//  host_err_o    out  1 [NrHosts]           response error
//  dev_req_o     out  1                     downstream request (always accepted)
//  dev_addr_o    out  AddressWidth          downstream address
//  dev_we_o      out  1                     downstream write enable
//  dev_be_o      out  DataWidth/8           downstream byte enables
//  dev_wdata_o   out  DataWidth             downstream write data
//  dev_rvalid_i  in   1                     downstream response valid (in order)
//  dev_rdata_i   in   DataWidth             downstream response data
//  dev_err_i     in   1                     downstream response error
//  timeout_o     out  1                     1-cycle pulse when a watchdog fires
//  spurious_o    out  1                     1-cycle pulse on an unowned rvalid
// BEHAVIOUR
//  Reset: all gnt/rvalid/err/dev_req/timeout_o/spurious_o = 0; rdata = 0.
//  Reset also clears the FIFO, rr pointer (=0), wait counter and stale counter.
//  Grant: comb. search from rr_ptr upward (wrapping) for the first asserted req.
//   - At most one grant per cycle.
//   - Grant only if FIFO not full; a full FIFO blocks the grant even if a pop
//     happens in the same cycle.
//   - On grant: dev_req_o=1 and dev_* mux the winner's fields in the same cycle,
//     the winner id is pushed to the FIFO, and rr_ptr <= winner+1 (mod NrHosts).
//   - No req: dev_req_o=0, dev_* = 0, rr_ptr holds.
//  Response: dev_rvalid_i with stale_cnt==0 and FIFO not empty -> pop head id h.
//   - Same cycle: host_rvalid_o[h]=1, host_rdata_o[h]=dev_rdata_i,
//     host_err_o[h]=dev_err_i. Zero added latency.
//  Watchdog: wait_cnt counts cycles while the FIFO is non-empty.
//   - Reset to 0 on each pop; frozen at 0 while empty.
//   - When wait_cnt==TimeoutCycles-1 with no rvalid that cycle: pop head,
//     host_rvalid_o[h]=1, host_err_o[h]=1, rdata=0, timeout_o=1,
//     stale_cnt++ (saturates at MaxOutstanding).
//   - rvalid and timeout in the same cycle: the rvalid wins, no timeout.
//  Stale: dev_rvalid_i while stale_cnt>0 -> dropped (no host rvalid),
//   stale_cnt--.
//  Spurious: dev_rvalid_i with stale_cnt==0 and FIFO empty -> dropped,
//   spurious_o=1.
//  Push and pop in the same cycle are legal; occupancy is unchanged.
//  Reset mid-transaction: outstanding entries are discarded. Hosts are reset
//   together with this block.
//  Writes also occupy a FIFO slot; devices must return rvalid for writes.
// STRUCTURE
//  Package bus_arb_pkg: HostIdW = $clog2(NrHosts) helper function; typedef
//   host_id_t.
//  Sub-module bus_arb_id_fifo: sync FIFO of host_id_t.
//   - Ports: push, pop, wdata, rdata(head), full, empty.
//   - Async active-low reset.
//  Top holds the rr grant logic, request mux, watchdog/stale counters and
//   response demux.
// TESTING
//  1. Hosts 0,1,2 hold req continuously, dev responds next cycle -> grant order
//     0,1,2,0,1,2; each rvalid goes only to its issuer.
//  2. MaxOutstanding=4, dev never responds -> 4 grants, then gnt=0 until a pop.
//  3. No rvalid for 256 cycles -> owner gets rvalid+err, rdata=0.
//     timeout_o pulses on cycle 256 after the grant.
//  4. Late rvalid after a timeout -> dropped, stale_cnt returns to 0.
//     The next real response still reaches its correct owner.
//  5. rvalid with empty FIFO -> spurious_o=1, no host rvalid.
//     rvalid on the exact timeout cycle -> normal response, timeout_o=0.
//  6. Assert rst_ni low with 3 transactions outstanding -> all outputs 0
//     immediately. After release, host 0 is granted first.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared defaults, host-id width helper and host id type for the bus arbiter
package bus_arb_pkg;
  localparam int DefNrHosts = 3;
  localparam int DefMaxOutstanding = 4;
  localparam int DefTimeoutCycles = 256;
  localparam int DefDataWidth = 32;
  localparam int DefAddressWidth = 32;
  function automatic int host_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int HostIdW = host_id_w(DefNrHosts);
  typedef logic [HostIdW-1:0] host_id_t;
endpackage

// File: rtl/bus_host_rr_arbiter_if.sv
// bus_host_rr_arbiter_if: host-side and device-side bus signals of the arbiter
interface bus_host_rr_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NrHosts = DefNrHosts,
  parameter int DataWidth = DefDataWidth,
  parameter int AddressWidth = DefAddressWidth
);
  logic [NrHosts-1:0]                    host_req_i;
  logic [NrHosts-1:0]                    host_gnt_o;
  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i;
  logic [NrHosts-1:0]                    host_we_i;
  logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i;
  logic [NrHosts-1:0]                    host_rvalid_o;
  logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o;
  logic [NrHosts-1:0]                    host_err_o;
  logic                                  dev_req_o;
  logic [AddressWidth-1:0]               dev_addr_o;
  logic                                  dev_we_o;
  logic [DataWidth/8-1:0]                dev_be_o;
  logic [DataWidth-1:0]                  dev_wdata_o;
  logic                                  dev_rvalid_i;
  logic [DataWidth-1:0]                  dev_rdata_i;
  logic                                  dev_err_i;
  logic                                  timeout_o;
  logic                                  spurious_o;
  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  dev_rvalid_i, dev_rdata_i, dev_err_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    output timeout_o, spurious_o
  );
  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output dev_rvalid_i, dev_rdata_i, dev_err_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    input  timeout_o, spurious_o
  );
endinterface

// File: rtl/bus_arb_id_fifo.sv
// bus_arb_id_fifo: in-order FIFO of response-owner host ids
module bus_arb_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int Depth = DefMaxOutstanding,
  parameter type T = host_id_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic pop_i,
  input  T     wdata_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(Depth);
  T             mem_q [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  assign full_o  = cnt_q == (AW+1)'(Depth);
  assign empty_o = cnt_q == '0;
  assign rdata_o = mem_q[rptr_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
      wptr_q <= wptr_q + AW'(push_i);
      rptr_q <= rptr_q + AW'(pop_i);
      cnt_q  <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/bus_host_rr_arbiter.sv
// bus_host_rr_arbiter: round-robin host arbiter with in-order response routing and watchdog
module bus_host_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NrHosts = DefNrHosts,
  parameter int MaxOutstanding = DefMaxOutstanding,
  parameter int TimeoutCycles = DefTimeoutCycles,
  parameter int DataWidth = DefDataWidth,
  parameter int AddressWidth = DefAddressWidth
) (
  input logic clk_i,
  input logic rst_ni,
  bus_host_rr_arbiter_if.slave bus
);
  localparam int IdW = host_id_w(NrHosts);
  localparam int WaitW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int StaleW = $clog2(MaxOutstanding + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TimeoutCycles - 1);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(MaxOutstanding);
  typedef logic [IdW-1:0] id_t;
  id_t rr_q, rr_d, win, head;
  logic found, gnt, full, empty, resp, tmo, pop, drop;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [StaleW-1:0] stale_q, stale_d;
  bus_arb_id_fifo #(.Depth(MaxOutstanding), .T(id_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt),
    .pop_i   (pop),
    .wdata_i (win),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // Outputs are gated by rst_ni so they drop the moment reset asserts.
  always_comb begin
    found = 1'b0;
    win = rr_q;
    for (int k = 0; k < NrHosts; k++) begin
      if (!found && bus.host_req_i[(int'(rr_q) + k) % NrHosts]) begin
        found = 1'b1;
        win = id_t'((int'(rr_q) + k) % NrHosts);
      end
    end
    gnt = found && !full && rst_ni;
    bus.host_gnt_o = '0;
    bus.host_gnt_o[win] = gnt;
    bus.dev_req_o = gnt;
    bus.dev_addr_o = gnt ? bus.host_addr_i[win] : '0;
    bus.dev_we_o = gnt ? bus.host_we_i[win] : 1'b0;
    bus.dev_be_o = gnt ? bus.host_be_i[win] : '0;
    bus.dev_wdata_o = gnt ? bus.host_wdata_i[win] : '0;
    rr_d = !gnt ? rr_q : (int'(win) == NrHosts - 1) ? '0 : win + 1'b1;
  end
  // A device rvalid retires a stale (timed-out) entry before it may answer the head.
  always_comb begin
    drop = rst_ni && bus.dev_rvalid_i && stale_q != '0;
    resp = rst_ni && bus.dev_rvalid_i && stale_q == '0 && !empty;
    tmo = rst_ni && !bus.dev_rvalid_i && !empty && wait_q == WaitMax;
    pop = resp || tmo;
    bus.spurious_o = rst_ni && bus.dev_rvalid_i && stale_q == '0 && empty;
    bus.timeout_o = tmo;
    bus.host_rvalid_o = '0;
    bus.host_err_o = '0;
    bus.host_rdata_o = '0;
    bus.host_rvalid_o[head] = pop;
    bus.host_err_o[head] = tmo || (resp && bus.dev_err_i);
    bus.host_rdata_o[head] = resp ? bus.dev_rdata_i : '0;
    wait_d = (pop || empty) ? '0 : (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
    stale_d = drop ? stale_q - 1'b1 : (tmo && stale_q != StaleMax) ? stale_q + 1'b1 : stale_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      wait_q  <= '0;
      stale_q <= '0;
    end else begin
      rr_q    <= rr_d;
      wait_q  <= wait_d;
      stale_q <= stale_d;
    end
  end
endmodule

// File: tb/tb_bus_host_rr_arbiter.sv
// tb_bus_host_rr_arbiter: directed and randomized checks against a queue-based reference model
module tb_bus_host_rr_arbiter;
  import bus_arb_pkg::*;
  localparam int N = 3, MAXO = 4, T = 256, DW = 32, AW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bus_host_rr_arbiter_if #(.NrHosts(N), .DataWidth(DW), .AddressWidth(AW)) bus ();
  bus_host_rr_arbiter #(
    .NrHosts(N), .MaxOutstanding(MAXO), .TimeoutCycles(T), .DataWidth(DW), .AddressWidth(AW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );
  int checks = 0, failures = 0;
  int q[$];
  int rr = 0, stale = 0, cyc = 0, since = 0;
  logic last_tmo;
  logic [N-1:0] last_gnt;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [N-1:0] req, input logic rv, input logic err = 1'b0);
    bus.host_req_i = req;
    for (int h = 0; h < N; h++) begin
      bus.host_addr_i[h] = $urandom;
      bus.host_wdata_i[h] = $urandom;
      bus.host_be_i[h] = 4'($urandom);
      bus.host_we_i[h] = 1'($urandom);
    end
    bus.dev_rvalid_i = rv;
    bus.dev_rdata_i = $urandom;
    bus.dev_err_i = err;
  endtask
  // Reference: owners in a queue, head age measured from the cycle it became head.
  task automatic step();
    int win;
    logic [N-1:0] eg, erv, eerr;
    logic [N-1:0][DW-1:0] erd;
    logic etmo, esp, popped, was_empty;
    logic [AW+DW+DW/8:0] edev;
    #2;
    win = -1;
    if (q.size() < MAXO)
      for (int k = 0; k < N; k++)
        if (win < 0 && bus.host_req_i[(rr + k) % N]) win = (rr + k) % N;
    eg = '0;
    edev = '0;
    if (win >= 0) begin
      eg[win] = 1'b1;
      edev = {bus.host_addr_i[win], bus.host_we_i[win], bus.host_be_i[win], bus.host_wdata_i[win]};
    end
    erv = '0; eerr = '0; erd = '0; etmo = 1'b0; esp = 1'b0; popped = 1'b0;
    was_empty = q.size() == 0;
    if (bus.dev_rvalid_i) begin
      if (stale > 0) stale--;
      else if (q.size() == 0) esp = 1'b1;
      else begin
        erv[q[0]] = 1'b1; eerr[q[0]] = bus.dev_err_i; erd[q[0]] = bus.dev_rdata_i; popped = 1'b1;
      end
    end else if (q.size() > 0 && cyc - since >= T - 1) begin
      erv[q[0]] = 1'b1; eerr[q[0]] = 1'b1; etmo = 1'b1; popped = 1'b1;
      if (stale < MAXO) stale++;
    end
    chk("gnt", bus.host_gnt_o, eg);
    chk("dev_req", bus.dev_req_o, win >= 0);
    chk("dev_fields", {bus.dev_addr_o, bus.dev_we_o, bus.dev_be_o, bus.dev_wdata_o}, edev);
    chk("rvalid", bus.host_rvalid_o, erv);
    chk("err", bus.host_err_o, eerr);
    chk("rdata", bus.host_rdata_o, erd);
    chk("timeout", bus.timeout_o, etmo);
    chk("spurious", bus.spurious_o, esp);
    last_tmo = bus.timeout_o;
    last_gnt = bus.host_gnt_o;
    @(posedge clk);
    if (popped) void'(q.pop_front());
    if (popped || was_empty) since = cyc + 1;
    if (win >= 0) begin
      q.push_back(win);
      rr = (win + 1) % N;
    end
    cyc++;
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    drive('1, 1'b1, 1'b1);
    #1;
    chk("rst_gnt", bus.host_gnt_o, 0);
    chk("rst_dev_req", bus.dev_req_o, 0);
    chk("rst_dev_addr", bus.dev_addr_o, 0);
    chk("rst_rvalid", bus.host_rvalid_o, 0);
    chk("rst_err", bus.host_err_o, 0);
    chk("rst_rdata", bus.host_rdata_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    chk("rst_spurious", bus.spurious_o, 0);
    q.delete();
    rr = 0;
    stale = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    int t1_ord[6] = '{0, 1, 2, 0, 1, 2};
    int n;
    int pr[5] = '{50, 0, 30, 5, 60};
    int len[5] = '{400, 1200, 400, 400, 300};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive('1, i > 0);
      step();
      chk("t1_order", last_gnt, 1 << t1_ord[i]);
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive('1, 1'b0);
      step();
      if (i >= 4) chk("t2_full_block", last_gnt, 0);
    end
    drive('1, 1'b1);
    step();
    chk("t2_block_on_pop", last_gnt, 0);
    drive('1, 1'b0);
    step();
    chk("t2_regrant", last_gnt, 3'b010);
    do_reset();
    chk("t6_rr_after_reset", dut.rr_q, 0);
    drive('1, 1'b0);
    step();
    chk("t6_first_grant", last_gnt, 3'b001);
    do_reset();
    drive(3'b010, 1'b0);
    step();
    n = 0;
    for (int i = 1; i <= 300 && n == 0; i++) begin
      drive('0, 1'b0);
      step();
      if (last_tmo) n = i;
    end
    chk("t3_timeout_cycle", n, 256);
    drive('0, 1'b1);
    step();
    drive(3'b100, 1'b0);
    step();
    drive('0, 1'b1, 1'b1);
    step();
    drive('0, 1'b1);
    step();
    drive(3'b001, 1'b0);
    step();
    for (int i = 0; i < 255; i++) begin
      drive('0, 1'b0);
      step();
    end
    drive('0, 1'b1);
    step();
    chk("t5_rvalid_beats_timeout", last_tmo, 0);
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < len[b]; i++) begin
        drive(($urandom_range(0, 99) < 40) ? N'($urandom) : '0,
              $urandom_range(0, 99) < pr[b], 1'($urandom));
        step();
      end
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
